fetch_stage: RTL

Instruction fetch stage for the 8-bit pipelined core. It sits directly upstream of decode and the ID/EX latch. It owns the PC and talks to instruction memory over a req/ack handshake that may stall for several cycles. It delivers fetched instructions through an IF/ID register that honours hazard stalls and branch redirects.

---
 rtl/fetch_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC owner and instruction fetch for the 8-bit pipelined core;
//            req/ack memory handshake feeding an IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic               clk1,
    input  logic               rst,

    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,

    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,

    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc1,
    output logic               ifid_valid
);

    localparam logic [1:0] c_START = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;
    localparam logic [1:0] c_DROP  = 2'd3;

    logic [1:0]         r_state,      w_state;
    logic [PC_W-1:0]    r_pc,         w_pc;
    logic [PC_W-1:0]    r_tgt,        w_tgt;
    logic [INSTR_W-1:0] r_buf,        w_buf;
    logic [PC_W-1:0]    r_buf_pc1,    w_buf_pc1;
    logic [INSTR_W-1:0] r_ifid_instr, w_ifid_instr;
    logic [PC_W-1:0]    r_ifid_pc1,   w_ifid_pc1;
    logic               r_ifid_valid, w_ifid_valid;
    logic [PC_W-1:0]    w_pc_inc;

    // Wraps modulo 2^PC_W by construction of the width.
    assign w_pc_inc = r_pc + PC_W'(1);

    always_comb begin
        w_state      = r_state;
        w_pc         = r_pc;
        w_tgt        = r_tgt;
        w_buf        = r_buf;
        w_buf_pc1    = r_buf_pc1;
        w_ifid_instr = r_ifid_instr;
        w_ifid_pc1   = r_ifid_pc1;
        w_ifid_valid = r_ifid_valid;

        case (r_state)
            c_START: begin
                w_state = c_FETCH;
            end

            c_FETCH: begin
                if (redirect) begin
                    w_ifid_valid = 1'b0;
                    if (imem_ack) begin
                        w_pc = redirect_pc;
                    end else begin
                        // Keep the address stable until the stale ack returns.
                        w_tgt   = redirect_pc;
                        w_state = c_DROP;
                    end
                end else if (imem_ack) begin
                    w_pc = w_pc_inc;
                    if (stall) begin
                        w_buf     = imem_rdata;
                        w_buf_pc1 = w_pc_inc;
                        w_state   = c_HOLD;
                    end else begin
                        w_ifid_instr = imem_rdata;
                        w_ifid_pc1   = w_pc_inc;
                        w_ifid_valid = 1'b1;
                    end
                end else if (!stall) begin
                    w_ifid_valid = 1'b0;
                end
            end

            c_HOLD: begin
                if (redirect) begin
                    w_pc         = redirect_pc;
                    w_ifid_valid = 1'b0;
                    w_state      = c_FETCH;
                end else if (!stall) begin
                    w_ifid_instr = r_buf;
                    w_ifid_pc1   = r_buf_pc1;
                    w_ifid_valid = 1'b1;
                    w_state      = c_FETCH;
                end
            end

            c_DROP: begin
                w_ifid_valid = 1'b0;
                if (redirect) begin
                    w_tgt = redirect_pc;
                end
                if (imem_ack) begin
                    w_pc    = redirect ? redirect_pc : r_tgt;
                    w_state = c_FETCH;
                end
            end

            default: begin
                w_state = c_START;
            end
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state      <= c_START;
            r_pc         <= RESET_PC;
            r_tgt        <= '0;
            r_buf        <= '0;
            r_buf_pc1    <= '0;
            r_ifid_instr <= '0;
            r_ifid_pc1   <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_tgt        <= w_tgt;
            r_buf        <= w_buf;
            r_buf_pc1    <= w_buf_pc1;
            r_ifid_instr <= w_ifid_instr;
            r_ifid_pc1   <= w_ifid_pc1;
            r_ifid_valid <= w_ifid_valid;
        end
    end

    assign imem_req   = (r_state == c_FETCH) || (r_state == c_DROP);
    assign imem_addr  = r_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc1   = r_ifid_pc1;
    assign ifid_valid = r_ifid_valid;

endmodule
`default_nettype wire
